// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider family.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int DEF_DIVIDEND_W = 26;

  // Iteration counter width for a given dividend width.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_DIVIDEND_W);

  // Divide-by-zero result: quotient saturates to all ones, flag set.
  localparam logic [63:0] DBZ_Q_FILL = '1;
  localparam logic        DBZ_FLAG   = 1'b1;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation; serves as abs() on operand entry
// and as sign correction of quotient/remainder on exit.
module div_sign_fix #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle on magnitudes,
// with start/busy/done handshake, signed mode and divide-by-zero detection.
module seq_divider
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = 26,
  parameter int DIVISOR_W  = 14,
  parameter int SIGNED_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = cnt_width(DIVIDEND_W);
  localparam logic [CW-1:0] LAST_ITER = CW'(DIVIDEND_W - 1);

  div_state_t              state_reg;
  logic [DIVIDEND_W-1:0]   dvd_reg;
  logic [DIVISOR_W:0]      rem_reg;
  logic [DIVISOR_W-1:0]    dsr_reg;
  logic [CW-1:0]           cnt_reg;
  logic                    q_neg_reg;
  logic                    r_neg_reg;
  logic                    op_dbz_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic [DIVIDEND_W-1:0]   quotient_reg;
  logic [DIVISOR_W-1:0]    remainder_reg;
  logic                    dbz_out_reg;

  logic                    signed_op;
  logic                    dividend_neg;
  logic                    divisor_neg;
  logic [DIVIDEND_W-1:0]   dividend_abs;
  logic [DIVISOR_W-1:0]    divisor_abs;
  logic [DIVISOR_W:0]      trial;
  logic [DIVISOR_W:0]      divisor_ext;
  logic                    fits;
  logic [DIVISOR_W:0]      rem_next;
  logic [DIVIDEND_W-1:0]   quotient_fixed;
  logic [DIVISOR_W-1:0]    remainder_fixed;

  assign signed_op    = (SIGNED_EN != 0) && signed_mode;
  assign dividend_neg = signed_op && dividend[DIVIDEND_W-1];
  assign divisor_neg  = signed_op && divisor[DIVISOR_W-1];

  div_sign_fix #(.W(DIVIDEND_W)) u_abs_dividend (
    .value  (dividend),
    .negate (dividend_neg),
    .result (dividend_abs)
  );

  div_sign_fix #(.W(DIVISOR_W)) u_abs_divisor (
    .value  (divisor),
    .negate (divisor_neg),
    .result (divisor_abs)
  );

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder is always below |divisor|, so the shifted value
  // never needs more than DIVISOR_W+1 bits.
  assign divisor_ext = {1'b0, dsr_reg};
  assign trial       = (rem_reg << 1) | {{DIVISOR_W{1'b0}}, dvd_reg[DIVIDEND_W-1]};
  assign fits        = (trial >= divisor_ext);
  assign rem_next    = fits ? (trial - divisor_ext) : trial;

  div_sign_fix #(.W(DIVIDEND_W)) u_fix_quotient (
    .value  (dvd_reg),
    .negate (q_neg_reg),
    .result (quotient_fixed)
  );

  div_sign_fix #(.W(DIVISOR_W)) u_fix_remainder (
    .value  (rem_reg[DIVISOR_W-1:0]),
    .negate (r_neg_reg),
    .result (remainder_fixed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      dvd_reg       <= '0;
      rem_reg       <= '0;
      dsr_reg       <= '0;
      cnt_reg       <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      op_dbz_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_out_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          busy_reg <= start;
          if (start) begin
            dsr_reg   <= divisor_abs;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            q_neg_reg <= dividend_neg ^ divisor_neg;
            r_neg_reg <= dividend_neg;
            if (divisor == '0) begin
              // Keep the raw dividend: its low bits become the remainder.
              op_dbz_reg <= 1'b1;
              dvd_reg    <= dividend;
              state_reg  <= FIX;
            end else begin
              op_dbz_reg <= 1'b0;
              dvd_reg    <= dividend_abs;
              state_reg  <= RUN;
            end
          end
        end

        RUN: begin
          rem_reg <= rem_next;
          dvd_reg <= {dvd_reg[DIVIDEND_W-2:0], fits};
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_ITER) begin
            state_reg <= FIX;
          end
        end

        FIX: begin
          done_reg  <= 1'b1;
          state_reg <= IDLE;
          if (op_dbz_reg) begin
            quotient_reg  <= DBZ_Q_FILL[DIVIDEND_W-1:0];
            remainder_reg <= dvd_reg[DIVISOR_W-1:0];
            dbz_out_reg   <= DBZ_FLAG;
          end else begin
            quotient_reg  <= quotient_fixed;
            remainder_reg <= remainder_fixed;
            dbz_out_reg   <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_out_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed checks of seq_divider against an arithmetic model.
module tb_seq_divider;

  localparam int DW = 26;
  localparam int VW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signed_mode;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int tests_run    = 0;
  int tests_failed = 0;

  seq_divider #(
    .DIVIDEND_W (DW),
    .DIVISOR_W  (VW),
    .SIGNED_EN  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division on the operands' numeric values.
  task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit sm,
                       output logic [DW-1:0] q, output logic [VW-1:0] r, output logic dbz);
    longint sa, sb, lq, lr;
    if (b == '0) begin
      q   = '1;
      r   = a[VW-1:0];
      dbz = 1'b1;
    end else begin
      sa = longint'(a);
      sb = longint'(b);
      if (sm && a[DW-1]) sa = sa - (longint'(1) <<< DW);
      if (sm && b[VW-1]) sb = sb - (longint'(1) <<< VW);
      lq  = sa / sb;
      lr  = sa % sb;
      q   = lq[DW-1:0];
      r   = lr[VW-1:0];
      dbz = 1'b0;
    end
  endtask

  // inject: pulse a conflicting start mid-RUN. hold: keep start high and
  // present the next operands in the done cycle. predriven: start is already
  // asserted with these operands from the previous op's done cycle.
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit sm,
                        input bit inject, input bit hold, input bit predriven,
                        input logic [DW-1:0] na, input logic [VW-1:0] nb, input bit nsm);
    int            n;
    bit            busy_ok;
    bit            seen;
    int            exp_lat;
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          edbz;
    if (!predriven) begin
      @(negedge clk);
      dividend    = a;
      divisor     = b;
      signed_mode = sm;
      start       = 1'b1;
    end
    model(a, b, sm, eq, er, edbz);
    exp_lat = (b == '0) ? 2 : DW + 2;
    n = 0;
    busy_ok = 1'b1;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (!hold && n == 1) start = 1'b0;
      if (inject && n == 5) begin
        start       = 1'b1;
        dividend    = ~a;
        divisor     = b + VW'(3);
        signed_mode = ~sm;
      end
      if (inject && n == 6) start = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("busy_held", 64'(busy_ok), 64'd1);
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("div_by_zero", 64'(div_by_zero), 64'(edbz));
    $display("[TB] op %0s 0x%0h / 0x%0h -> q=0x%0h r=0x%0h dbz=%0b lat=%0d",
             sm ? "s" : "u", a, b, quotient, remainder, div_by_zero, n);
    if (hold) begin
      dividend    = na;
      divisor     = nb;
      signed_mode = nsm;
    end else begin
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);
      check("busy_drop", 64'(busy), 64'd0);
    end
  endtask

  task automatic op(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit sm);
    run_op(a, b, sm, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int            extra_done;
    logic [31:0]   r32;
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;
    bit            rsm;

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);

    op(26'd1000000, 14'd7, 1'b0);
    op(26'h3FFFF9C, 14'd7, 1'b1);       // -100 / 7
    op(26'd100, 14'h3FF9, 1'b1);        // 100 / -7
    op(26'h3FFFF9C, 14'h3FF9, 1'b1);    // -100 / -7
    op(26'h3FFFFFF, 14'd1, 1'b0);
    op(26'h2000000, 14'h3FFF, 1'b1);    // MIN / -1
    op(26'd5, 14'd9, 1'b0);
    op(26'd1234, 14'd0, 1'b0);
    op(26'd10, 14'd3, 1'b0);
    op(26'h3FFFFF0, 14'd0, 1'b1);

    run_op(26'd99999, 14'd123, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    run_op(26'd777777, 14'd55, 1'b0, 1'b0, 1'b1, 1'b0, 26'h3FFF000, 14'h2001, 1'b1);
    run_op(26'h3FFF000, 14'h2001, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    dividend = 26'd12345; divisor = 14'd7; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_quotient", 64'(quotient), 64'd0);
    check("midrst_remainder", 64'(remainder), 64'd0);
    check("midrst_dbz", 64'(div_by_zero), 64'd0);
    extra_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) extra_done++;
    end
    check("midrst_no_done", 64'(extra_done), 64'd0);
    op(26'd50, 14'd5, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r32 = $urandom();
      ra  = r32[DW-1:0];
      r32 = $urandom();
      rb  = r32[VW-1:0];
      if ($urandom_range(7) == 0) rb = '0;
      if ($urandom_range(9) == 0) begin
        ra = 26'h2000000;
        rb = 14'h3FFF;
      end
      rsm = bit'($urandom_range(1));
      op(ra, rb, rsm);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle restoring divider. Successor to the fixed 26/14-bit unsigned divider.
- Adds an explicit start/busy/done handshake, remainder output, a signed mode, divide-by-zero detection and synchronous reset.
- Sits beside the datapath blocks that need a scaled quotient. The consumer holds off on `busy` and captures results on `done`.

Parameters:
- DIVIDEND_W, 26, dividend and quotient width in bits (≥2)
- DIVISOR_W, 14, divisor and remainder width in bits (≥2, ≤ DIVIDEND_W)
- SIGNED_EN, 1, 1 = `signed_mode` input honoured; 0 = block is unsigned-only and `signed_mode` is ignored

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while `busy`=0
- signed_mode  input  1  1 = two's-complement operands; sampled with `start`
- dividend  input  DIVIDEND_W  numerator; sampled with `start`
- divisor  input  DIVISOR_W  denominator; sampled with `start`
- busy  output  1  high from the cycle after `start` is accepted until the cycle `done` is high, inclusive
- done  output  1  one-cycle pulse; results valid
- quotient  output  DIVIDEND_W  result, held until next `done`
- remainder  output  DIVISOR_W  result, held until next `done`
- div_by_zero  output  1  flag for the last completed operation, held until next `done`

Behaviour:
- Reset
  - `rst`=1 at an edge forces IDLE.
  - `busy`, `done`, `quotient`, `remainder`, `div_by_zero` all go to 0.
  - Takes priority over everything, including mid-operation; the in-flight result is discarded with no `done`.
- Single clock; no combinational path from inputs to outputs.
- States: IDLE, RUN, FIX.
- IDLE
  - `start`=1 at edge E0: latch operands and mode.
  - If divisor==0: go to FIX directly.
  - Otherwise: load |dividend| into the shift register, clear the partial remainder (DIVISOR_W+1 bits), clear the counter, go to RUN.
  - `busy`=1 after E0.
- RUN
  - One quotient bit per cycle, MSB first.
  - Shift the partial remainder left, bringing in the next dividend bit.
  - If it is ≥ |divisor|, subtract and set the quotient bit to 1.
  - After exactly DIVIDEND_W iterations (edges E1..E_DIVIDEND_W) go to FIX.
- FIX (edge E_DIVIDEND_W+1)
  - Apply sign correction, register the outputs, pulse `done`=1 for one cycle, return to IDLE.
  - `busy` drops with `done` at the next edge.
- Latency: `done` is high in the cycle after edge E_DIVIDEND_W+1, i.e. DIVIDEND_W+2 cycles after the start cycle. For divide-by-zero this is 2 cycles.
- Back-to-back: `start` may be asserted in the cycle `done` is high; it is accepted at the next edge, since the FSM is back in IDLE.
- `start` while `busy`=1 is ignored: no queueing, no effect on the current operation.
- Unsigned result: quotient = floor(a/b), remainder = a mod b.
- Signed result
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Magnitudes are computed on absolute values. |MIN| = 2^(DIVIDEND_W-1) must be representable in the unsigned DIVIDEND_W datapath.
- Divide by zero: `div_by_zero`=1, quotient = all ones (-1 when signed), remainder = dividend[DIVISOR_W-1:0].
- Signed overflow: MIN / -1 gives quotient = MIN, remainder = 0, `div_by_zero`=0. No separate flag.
- Outputs change only at the edge that raises `done`, or at reset.

Decomposition:
- Shared package `divider_pkg` holds:
  - the state enum (IDLE, RUN, FIX);
  - localparam CNT_W = clog2(DIVIDEND_W+1);
  - the divide-by-zero result constants.
- One sub-module, `div_sign_fix`, is natural. It is combinational and parametrised by width. It computes abs() of the operands on entry and conditional negation of quotient/remainder on exit, so the sign logic is shared and tested once.
- Core FSM and shift/subtract datapath stay in `seq_divider`.

Test Plan:
- Unsigned, defaults: 1000000 / 7 → quotient 142857, remainder 1; `done` exactly 28 cycles after the start cycle; `busy` high throughout.
- Signed: -100 / 7 → quotient -14, remainder -2. 100 / -7 → quotient -14, remainder 2. -100 / -7 → quotient 14, remainder -2.
- Boundaries
  - Unsigned 0x3FFFFFF / 1 → quotient 0x3FFFFFF, remainder 0.
  - Signed 0x2000000 (MIN) / 0x3FFF (-1) → quotient 0x2000000, remainder 0.
  - 5 / 9 → quotient 0, remainder 5.
- Divide by zero: 1234 / 0 → `div_by_zero`=1, quotient 0x3FFFFFF, remainder 1234, `done` 2 cycles after start. A following 10 / 3 clears the flag → quotient 3, remainder 1.
- Handshake
  - A second `start` with different operands pulsed mid-RUN is ignored; the first result is intact.
  - `start` held high through `done` launches the next operation immediately.
- Reset: `rst` at iteration 10 → all outputs 0, no `done` pulse. A new 50 / 5 afterwards → quotient 10, remainder 0 with nominal latency.
